// File: rtl/ex_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage: one shift/add-subtract
// step per cycle on a shared datapath, sign fix-up in a final cycle, results in HI/LO.
module ex_muldiv_seq #(
  parameter int len      = 32,
  parameter int NB_MD_OP = 2,
  parameter int NB_COUNT = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [NB_MD_OP-1:0] i_op,
  input  logic [len-1:0]      i_dato1,
  input  logic [len-1:0]      i_dato2,
  input  logic                i_flush,
  output logic                o_stall,
  output logic                o_busy,
  output logic                o_done,
  output logic [len-1:0]      o_hi,
  output logic [len-1:0]      o_lo,
  output logic                o_div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [len-1:0] mag_of(input logic [len-1:0] x, input logic is_signed);
    if (is_signed && x[len-1]) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

  function automatic logic [len-1:0] neg_word(input logic [len-1:0] x, input logic en);
    if (en) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

  function automatic logic [2*len-1:0] neg_dword(input logic [2*len-1:0] x, input logic en);
    if (en) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

  state_t                state_r, state_nxt_s;
  logic [NB_COUNT-1:0]   count_r;
  logic [NB_MD_OP-1:0]   op_r;
  logic                  neg_q_r, neg_r_r, zdiv_r, dbz_r;
  logic [len:0]          a_r;          // upper accumulator / partial remainder
  logic [len-1:0]        b_r;          // multiplier -> low product, or dividend -> quotient
  logic [len-1:0]        m_r;          // multiplicand / divisor magnitude
  logic [len-1:0]        hi_r, lo_r;

  logic                  start_ok_s, last_iter_s, commit_s, is_div_s, in_signed_s;
  logic [len-1:0]        mag1_s, mag2_s;
  logic [len:0]          mul_sum_s, div_trial_s, div_diff_s, step_a_s;
  logic                  div_ge_s;
  logic [len-1:0]        step_b_s;
  logic [2*len-1:0]      prod_fix_s;
  logic [len-1:0]        fix_hi_s, fix_lo_s;

  assign start_ok_s  = (state_r == IDLE) && i_start && !i_flush;
  assign last_iter_s = (count_r == NB_COUNT'(len - 1));
  assign commit_s    = (state_r == FIX) && !i_flush;
  assign is_div_s    = op_r[1];
  assign in_signed_s = ~i_op[0];
  assign mag1_s      = mag_of(i_dato1, in_signed_s);
  assign mag2_s      = mag_of(i_dato2, in_signed_s);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush aborts from CALC or FIX.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (i_flush) begin
          state_nxt_s = IDLE;
        end else if (last_iter_s) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    step_a_s    = a_r;
    step_b_s    = b_r;
    div_trial_s = {a_r[len-1:0], b_r[len-1]};
    div_ge_s    = (div_trial_s >= {1'b0, m_r});
    div_diff_s  = div_trial_s - {1'b0, m_r};
    if (b_r[0]) begin
      mul_sum_s = a_r + {1'b0, m_r};
    end else begin
      mul_sum_s = a_r;
    end
    if (is_div_s) begin
      step_b_s = {b_r[len-2:0], div_ge_s};
      if (div_ge_s) begin
        step_a_s = div_diff_s;
      end else begin
        step_a_s = div_trial_s;
      end
    end else begin
      step_a_s = {1'b0, mul_sum_s[len:1]};
      step_b_s = {mul_sum_s[0], b_r[len-1:1]};
    end
  end

  // Sign correction of the finished magnitudes, consumed in FIX.
  always_comb begin
    prod_fix_s = neg_dword({a_r[len-1:0], b_r}, neg_q_r);
    if (is_div_s) begin
      fix_hi_s = neg_word(a_r[len-1:0], neg_r_r);
      fix_lo_s = neg_word(b_r, neg_q_r);
    end else begin
      fix_hi_s = prod_fix_s[2*len-1:len];
      fix_lo_s = prod_fix_s[len-1:0];
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= {NB_COUNT{1'b0}};
      op_r    <= {NB_MD_OP{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      zdiv_r  <= 1'b0;
      dbz_r   <= 1'b0;
      a_r     <= {(len+1){1'b0}};
      b_r     <= {len{1'b0}};
      m_r     <= {len{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            op_r    <= i_op;
            count_r <= {NB_COUNT{1'b0}};
            a_r     <= {(len+1){1'b0}};
            b_r     <= i_op[1] ? mag1_s : mag2_s;
            m_r     <= i_op[1] ? mag2_s : mag1_s;
            neg_q_r <= in_signed_s & (i_dato1[len-1] ^ i_dato2[len-1]);
            neg_r_r <= in_signed_s & i_dato1[len-1];
            zdiv_r  <= i_op[1] && (i_dato2 == {len{1'b0}});
            dbz_r   <= 1'b0;
          end
        end
        CALC: begin
          a_r     <= step_a_s;
          b_r     <= step_b_s;
          count_r <= count_r + NB_COUNT'(1);
          if (last_iter_s && !i_flush) begin
            dbz_r <= zdiv_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO commit; a flush in FIX leaves the previous result in place.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_r <= {len{1'b0}};
      lo_r <= {len{1'b0}};
    end else if (commit_s) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end
  end

  // The result is presented during FIX itself so the stalled consumer sees it as it advances.
  assign o_hi          = commit_s ? fix_hi_s : hi_r;
  assign o_lo          = commit_s ? fix_lo_s : lo_r;
  assign o_done        = commit_s;
  assign o_busy        = (state_r != IDLE);
  assign o_stall       = start_ok_s || (state_r == CALC);
  assign o_div_by_zero = dbz_r;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: randomized and directed ops checked against
// a plain-arithmetic reference model; a monitor compares whenever o_done fires.
module tb_ex_muldiv_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_dato1 = 32'h0;
  logic [31:0] i_dato2 = 32'h0;
  logic        i_flush = 1'b0;
  logic        o_stall, o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  ex_muldiv_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_dato1(i_dato1), .i_dato2(i_dato2), .i_flush(i_flush),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done),
    .o_hi(o_hi), .o_lo(o_lo), .o_div_by_zero(o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results straight from integer arithmetic on the architectural operands.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        hi = p[63:32]; lo = p[31:0];
      end
      2'b01: begin
        p = {32'h0, a} * {32'h0, b};
        hi = p[63:32]; lo = p[31:0];
      end
      2'b10: begin
        if (b == 32'h0) begin
          dbz = 1'b1;
          lo  = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          hi  = a;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      default: begin
        if (b == 32'h0) begin
          dbz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_stall) stall_cnt <= stall_cnt + 1;
    if (i_rst_n && o_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("hi", {32'h0, o_hi}, {32'h0, e.hi});
        chk("lo", {32'h0, o_lo}, {32'h0, e.lo});
        chk("div_by_zero", {63'h0, o_div_by_zero}, {63'h0, e.dbz});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (!o_busy) return;
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (sbq.size() == 0) return;
    end
    chk("done_timeout", 64'd1, 64'd0);
    sbq.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [31:0] hi, lo;
    logic        dbz;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_op = op; i_dato1 = a; i_dato2 = b;
    if (push) begin
      model(op, a, b, hi, lo, dbz);
      sbq.push_back('{hi, lo, dbz, cyc + 33});
      last_hi = hi; last_lo = lo;
    end
    @(posedge i_clk); #1;
    i_start = 1'b0; i_dato1 = $urandom; i_dato2 = $urandom; i_op = 2'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    issue(op, a, b, 1'b1);
    wait_drain();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_hi", {32'h0, o_hi}, 64'h0);
    chk("rst_lo", {32'h0, o_lo}, 64'h0);
    chk("rst_done", {63'h0, o_done}, 64'h0);
    chk("rst_busy", {63'h0, o_busy}, 64'h0);
    chk("rst_dbz", {63'h0, o_div_by_zero}, 64'h0);
    chk("rst_stall", {63'h0, o_stall}, 64'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // MULTU all-ones: result, latency and stall length
    wait_idle();
    s0 = stall_cnt;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    wait_idle();
    chk("stall_cycles", 64'(stall_cnt - s0), 64'd33);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);

    // DIV -7/2 with a spurious start while in CALC
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b1; i_op = 2'b01; i_dato1 = 32'd5; i_dato2 = 32'd5;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_drain();

    // DIVU by zero, sticky flag, cleared by next start
    run_op(2'b11, 32'd100, 32'd0);
    wait_idle();
    chk("dbz_sticky", {63'h0, o_div_by_zero}, 64'd1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    @(negedge i_clk);
    chk("dbz_cleared", {63'h0, o_div_by_zero}, 64'd0);
    wait_drain();

    // flush beats a same-cycle start in IDLE
    wait_idle();
    @(posedge i_clk); #1;
    i_start = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_dato1 = 32'd3; i_dato2 = 32'd3;
    @(negedge i_clk);
    chk("flush_start_stall", {63'h0, o_stall}, 64'd0);
    @(posedge i_clk); #1;
    i_start = 1'b0; i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_start_busy", {63'h0, o_busy}, 64'd0);

    // DIVU 9/2 flushed at cycle 10, with an ignored start in CALC
    wait_idle();
    issue(2'b11, 32'd9, 32'd2, 1'b0);
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b1; i_dato1 = 32'd100;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_busy", {63'h0, o_busy}, 64'd0);
    chk("flush_hi", {32'h0, o_hi}, {32'h0, last_hi});
    chk("flush_lo", {32'h0, o_lo}, {32'h0, last_lo});
    repeat (40) @(negedge i_clk);
    chk("flush_hi_hold", {32'h0, o_hi}, {32'h0, last_hi});

    // reset asserted in CALC cycle 5
    run_op(2'b00, 32'h1234_5678, 32'h0000_0100);
    wait_idle();
    issue(2'b11, 32'd9, 32'd2, 1'b0);
    repeat (5) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_hi", {32'h0, o_hi}, 64'h0);
    chk("midrst_lo", {32'h0, o_lo}, 64'h0);
    chk("midrst_busy", {63'h0, o_busy}, 64'h0);
    chk("midrst_done", {63'h0, o_done}, 64'h0);
    chk("midrst_stall", {63'h0, o_stall}, 64'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    last_hi = 32'h0; last_lo = 32'h0;
    run_op(2'b10, 32'd1000, 32'hFFFF_FFF9);

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick());
    end

    wait_idle();
    chk("queue_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
